cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit processor core. Owns the program counter and instruction register, and drives instruction-memory and data-memory handshakes. Issues one-cycle strobes that tell the decode/control logic and datapath when to evaluate, write the register file or access memory. Sits between instruction memory, data memory and the per-instruction control decode.

---
 rtl/cpu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core. Owns the
// program counter and instruction register, drives the instruction- and
// data-memory handshakes and emits the one-cycle strobes that time the
// datapath (exec_en, rf_we) and instruction completion (retire).
//
// Ports
//   clk         core clock, rising edge
//   rst         asynchronous, active-low reset
//   run         1 = execute, 0 = stop at next instruction boundary
//   imem_valid  instruction word available for the current fetch
//   imem_data   instruction word, latched into ir on imem_valid in FETCH
//   zero        ALU zero flag, used by beq in EXEC
//   dmem_ready  data memory completed the current access (MEM only)
//   pc          program counter / instruction address
//   imem_req    high throughout FETCH
//   ir          latched instruction
//   exec_en     one-cycle pulse in EXEC
//   dmem_req    high throughout MEM
//   dmem_we     high with dmem_req for sw
//   rf_we       one-cycle pulse in WB
//   retire      high on the last cycle of each completed instruction
//   retired     count of completed instructions (wraps)
//   state       IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//   halted      high in HALT
//   illegal     sticky; set when an illegal instruction halts the core
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 imem_valid,
    input  logic [15:0]          imem_data,
    input  logic                 zero,
    input  logic                 dmem_ready,
    output logic [7:0]           pc,
    output logic                 imem_req,
    output logic [15:0]          ir,
    output logic                 exec_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b0010;

    state_t                state_reg, state_next;
    logic [7:0]            pc_reg, pc_next;
    logic [15:0]           ir_reg, ir_next;
    logic                  illegal_reg, illegal_next;
    logic [CNT_WIDTH-1:0]  retired_reg;
    logic                  imem_req_reg, exec_en_reg, dmem_req_reg;
    logic                  dmem_we_reg, rf_we_reg, halted_reg;
    logic                  complete;

    // Instruction classification from the latched word
    logic [3:0] opcode;
    logic       func_ok, is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;
    logic [7:0] pc_inc, br_target;

    assign opcode   = ir_reg[15:12];
    assign is_r     = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_legal = (is_r && func_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

    always_comb begin
        func_ok = 1'b0;
        case (ir_reg[2:0])
            3'b000, 3'b010, 3'b100, 3'b101: func_ok = 1'b1;
            default:                        func_ok = 1'b0;
        endcase
    end

    // 8-bit adds wrap naturally; offset is sign-extended from 6 bits
    assign pc_inc    = pc_reg + 8'd1;
    assign br_target = pc_inc + {{2{ir_reg[5]}}, ir_reg[5:0]};

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        illegal_next = illegal_reg;
        complete     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_next    = imem_data;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_next = EXEC;
                end else begin
                    state_next   = HALT;
                    illegal_next = 1'b1;
                end
            end
            EXEC: begin
                if (is_r || is_addi) begin
                    state_next = WB;
                end else if (is_lw || is_sw) begin
                    state_next = MEM;
                end else if (is_beq) begin
                    pc_next  = zero ? br_target : pc_inc;
                    complete = 1'b1;
                end else begin
                    pc_next  = ir_reg[7:0];
                    complete = 1'b1;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (is_lw) begin
                        state_next = WB;
                    end else begin
                        pc_next  = pc_inc;
                        complete = 1'b1;
                    end
                end
            end
            WB: begin
                pc_next  = pc_inc;
                complete = 1'b1;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
        // run is only sampled at the instruction boundary
        if (complete) state_next = run ? FETCH : IDLE;
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            ir_reg       <= 16'h0000;
            illegal_reg  <= 1'b0;
            retired_reg  <= '0;
            imem_req_reg <= 1'b0;
            exec_en_reg  <= 1'b0;
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            rf_we_reg    <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            illegal_reg  <= illegal_next;
            retired_reg  <= retired_reg + CNT_WIDTH'(complete);
            imem_req_reg <= (state_next == FETCH);
            exec_en_reg  <= (state_next == EXEC);
            dmem_req_reg <= (state_next == MEM);
            dmem_we_reg  <= (state_next == MEM) && is_sw;
            rf_we_reg    <= (state_next == WB);
            halted_reg   <= (state_next == HALT);
        end
    end

    // retire is combinational so that sw can complete on the very cycle
    // dmem_ready arrives
    assign retire   = complete;
    assign pc       = pc_reg;
    assign ir       = ir_reg;
    assign illegal  = illegal_reg;
    assign retired  = retired_reg;
    assign state    = state_reg;
    assign imem_req = imem_req_reg;
    assign exec_en  = exec_en_reg;
    assign dmem_req = dmem_req_reg;
    assign dmem_we  = dmem_we_reg;
    assign rf_we    = rf_we_reg;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        zero = 1'b0;
    logic        dmem_ready = 1'b0;
    logic [7:0]  pc;
    logic        imem_req;
    logic [15:0] ir;
    logic        exec_en, dmem_req, dmem_we, rf_we, retire, halted, illegal;
    logic [15:0] retired;
    logic [2:0]  state;

    cpu_sequencer #(.RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_valid(imem_valid),
        .imem_data(imem_data), .zero(zero), .dmem_ready(dmem_ready),
        .pc(pc), .imem_req(imem_req), .ir(ir), .exec_en(exec_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .retire(retire), .retired(retired), .state(state),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Instruction kinds used by the reference model
    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_ADDI = 4;
    localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8, K_ILL = 9;

    int checks = 0;
    int errors = 0;
    int pc_m   = 0;   // architectural pc expected by the model
    int ret_m  = 0;   // retired-instruction count expected by the model

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] make_word(input int k);
        logic [15:0] w;
        w = 16'($urandom);
        case (k)
            K_ADD:  begin w[15:12] = 4'h0; w[2:0] = 3'b000; end
            K_SUB:  begin w[15:12] = 4'h0; w[2:0] = 3'b010; end
            K_AND:  begin w[15:12] = 4'h0; w[2:0] = 3'b100; end
            K_OR:   begin w[15:12] = 4'h0; w[2:0] = 3'b101; end
            K_ADDI: w[15:12] = 4'h4;
            K_LW:   w[15:12] = 4'hB;
            K_SW:   w[15:12] = 4'hF;
            K_BEQ:  w[15:12] = 4'h8;
            default: w[15:12] = 4'h2;
        endcase
        return w;
    endfunction

    // Asynchronous reset with immediate checks, then a release cycle in IDLE
    // carrying stale memory responses that must be ignored.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'h00);
        chk({tag, "_ir"}, 32'(ir), 32'h0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_strobes"}, 32'({imem_req, exec_en, dmem_req, dmem_we, rf_we, retire, halted}), 32'd0);
        step();
        rst        = 1'b1;
        run        = 1'b1;
        imem_valid = 1'b1;
        dmem_ready = 1'b1;
        imem_data  = 16'($urandom) | 16'h0001;
        step();
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk({tag, "_resume_state"}, 32'(state), 32'd1);
        chk({tag, "_resume_ir"}, 32'(ir), 32'h0);
        chk({tag, "_resume_pc"}, 32'(pc), 32'h00);
        pc_m  = 0;
        ret_m = 0;
        #1;
    endtask

    // Drives one instruction from its first FETCH cycle until it retires
    // (or the core halts), then compares against the instruction-level model.
    task automatic run_instr(input int k, input logic [15:0] w, input bit z,
                             input int iw, input int dw, input bit drop_run);
        int cyc = 0, fcnt = 0, memc = 0, rfc = 0, exc = 0, wec = 0;
        int npc, lat, off;
        bit done = 0;
        logic [11:0] hist = 12'h0;
        while (!done && cyc < 200) begin
            imem_valid = imem_req ? (fcnt == iw) : 1'($urandom);
            imem_data  = imem_req ? w : 16'($urandom);
            dmem_ready = dmem_req ? (memc == dw) : 1'($urandom);
            zero       = (state == 3'd3) ? z : 1'($urandom);
            if (dmem_req && drop_run) run = 1'b0;
            #1;
            if (imem_req && fcnt == 0) chk("fetch_pc", 32'(pc), 32'(pc_m));
            if (imem_req) fcnt++;
            if (dmem_req) memc++;
            if (rf_we) rfc++;
            if (exec_en) exc++;
            if (dmem_we) wec++;
            cyc++;
            hist = {hist[8:0], state};
            if (retire || halted) done = 1;
            step();
        end
        chk("done_in_budget", 32'(done), 32'd1);
        if (k == K_ILL) begin
            chk("ill_halted", 32'(halted), 32'd1);
            chk("ill_flag", 32'(illegal), 32'd1);
            chk("ill_state", 32'(state), 32'd6);
            chk("ill_pc", 32'(pc), 32'(pc_m));
            chk("ill_retired", 32'(retired), 32'(ret_m));
            $display("instr %h illegal pc=%0h halted=%0b illegal=%0b", w, pc, halted, illegal);
            return;
        end
        npc = (pc_m + 1) & 255;
        case (k)
            K_BEQ: begin
                off = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
                if (z) npc = (pc_m + 1 + off) & 255;
                lat = 3;
            end
            K_J:  begin npc = int'(w[7:0]); lat = 3; end
            K_LW: lat = 5 + dw;
            K_SW: lat = 4 + dw;
            default: lat = 4;
        endcase
        lat   = lat + iw;
        pc_m  = npc;
        ret_m = (ret_m + 1) & 16'hFFFF;
        chk("latency", 32'(cyc), 32'(lat));
        chk("pc", 32'(pc), 32'(pc_m));
        chk("retired", 32'(retired), 32'(ret_m));
        chk("exec_en_pulses", 32'(exc), 32'd1);
        chk("rf_we_pulses", 32'(rfc), (k <= K_LW) ? 32'd1 : 32'd0);
        chk("dmem_cycles", 32'(memc), (k == K_LW || k == K_SW) ? 32'(dw + 1) : 32'd0);
        chk("dmem_we_cycles", 32'(wec), (k == K_SW) ? 32'(dw + 1) : 32'd0);
        chk("next_state", 32'(state), run ? 32'd1 : 32'd0);
        if (iw == 0 && k <= K_ADDI)
            chk("seq_alu", 32'(hist), 32'({3'd1, 3'd2, 3'd3, 3'd5}));
        if (iw == 0 && k == K_SW && dw == 0)
            chk("seq_sw", 32'(hist), 32'({3'd1, 3'd2, 3'd3, 3'd4}));
        if (iw == 0 && (k == K_BEQ || k == K_J))
            chk("seq_br", 32'(hist[8:0]), 32'({3'd1, 3'd2, 3'd3}));
        $display("instr %h kind=%0d z=%0b iw=%0d dw=%0d cycles=%0d pc=%0h retired=%0d",
                 w, k, z, iw, dw, cyc, pc, retired);
    endtask

    // In HALT, memory responses must be ignored and pc/ir must hold.
    task automatic halt_hold(input logic [15:0] w);
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b1;
            dmem_ready = 1'b1;
            imem_data  = 16'($urandom);
            #1;
            chk("halt_state", 32'(state), 32'd6);
            chk("halt_ir", 32'(ir), 32'(w));
            chk("halt_pc", 32'(pc), 32'(pc_m));
            chk("halt_imem_req", 32'(imem_req), 32'd0);
            step();
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        int k, n;
        #2;
        do_reset("por");

        // Basic flows
        run_instr(K_ADD, 16'h0000, 1'b0, 0, 0, 1'b0);
        run_instr(K_LW,  16'hB000, 1'b0, 0, 3, 1'b0);
        run_instr(K_SW,  16'hF000, 1'b0, 0, 0, 1'b0);

        // Branch arithmetic and pc wrap
        run_instr(K_J,   16'h2010, 1'b0, 0, 0, 1'b0);
        run_instr(K_BEQ, 16'h803E, 1'b1, 0, 0, 1'b0);
        run_instr(K_J,   16'h2010, 1'b0, 1, 0, 1'b0);
        run_instr(K_BEQ, 16'h803E, 1'b0, 0, 0, 1'b0);
        run_instr(K_J,   16'h20FF, 1'b0, 0, 0, 1'b0);
        run_instr(K_ADD, 16'h0000, 1'b0, 0, 0, 1'b0);

        // run dropped during MEM of lw: completes, then parks in IDLE
        run_instr(K_LW,  16'hB000, 1'b0, 0, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'($urandom);
            dmem_ready = 1'($urandom);
            #1;
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_pc", 32'(pc), 32'(pc_m));
            step();
        end
        imem_valid = 1'b0;
        run = 1'b1;
        step();
        chk("resume_fetch", 32'(state), 32'd1);
        run_instr(K_ADDI, make_word(K_ADDI), 1'b0, 0, 0, 1'b0);

        // Illegal opcode and illegal R-type func
        run_instr(K_ILL, 16'h7000, 1'b0, 0, 0, 1'b0);
        halt_hold(16'h7000);
        do_reset("rst_after_ill_op");
        run_instr(K_ADD, 16'h0000, 1'b0, 0, 0, 1'b0);
        run_instr(K_ILL, 16'h0001, 1'b0, 1, 0, 1'b0);
        halt_hold(16'h0001);
        do_reset("rst_after_ill_func");

        // Randomized legal instruction stream
        n = 150;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 8));
            run_instr(k, make_word(k), 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset in the middle of a FETCH wait
        imem_valid = 1'b0;
        step();
        step();
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        do_reset("rst_mid_fetch");

        // Reset in the middle of a MEM wait
        run_instr(K_J, 16'h2055, 1'b0, 0, 0, 1'b0);
        imem_valid = 1'b1;
        imem_data  = 16'hB000;
        step();
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        for (int i = 0; i < 6 && !dmem_req; i++) step();
        step();
        chk("mid_mem_req", 32'(dmem_req), 32'd1);
        do_reset("rst_mid_mem");

        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 8));
            run_instr(k, make_word(k), 1'($urandom), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
